// File: rtl/cpr_accum_ctrl.sv
// Multi-operand accumulator: each beat folds Lanes operands into a carry-save pair
// through a row of (Lanes+2,2) compressor columns; the last beat is resolved with one CPA.
`timescale 1ns/1ps
module cpr_accum_ctrl #(
   parameter int          Width    = 8,
   parameter int          Lanes    = 4,
   parameter int          MaxBeats = 4,
   parameter logic [1:0]  Speed    = 2'b10,
   localparam int         AccWidth = Width + $clog2(Lanes*MaxBeats),
   localparam int         CntWidth = $clog2(MaxBeats+1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [Lanes*Width-1:0] in_data_i,
   input  logic [Lanes-1:0]       in_mask_i,
   input  logic                   in_last_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [AccWidth-1:0]    out_sum_o,
   output logic [CntWidth-1:0]    out_count_o,
   output logic                   out_ovf_o
);

   localparam int M   = Lanes + 2;
   localparam int CiW = M - 3;
   localparam int NP  = 3*M - 5;

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_e;

   state_e                 state_q, state_d;
   logic [AccWidth-1:0]    sum_q, carry_q, res_q;
   logic [AccWidth-1:0]    sum_in, carry_in, sum_d, carry_d;
   logic [CntWidth-1:0]    cnt_q;
   logic                   ovf_q;
   logic                   acc;
   logic [Lanes-1:0][AccWidth-1:0] op;
   logic [M-1:0]           x;
   logic [CiW-1:0]         ci;
   logic [CiW+1:0]         r;

   // One compressor column. Result packing: {C, S, CO[CiW-1:0]}.
   // Tree mode reduces a FIFO of bits so incoming CI bits enter the last FA levels.
   function automatic logic [CiW+1:0] col_fn(input logic [M-1:0] xi, input logic [CiW-1:0] cin);
      logic [NP-1:0]  p;
      logic [CiW+1:0] res;
      logic           s, a, b, c, cy;
      res = '0;
      p   = '0;
      if (Speed == 2'b00) begin
         s      = xi[0] ^ xi[1] ^ xi[2];
         res[0] = (xi[0] & xi[1]) | (xi[0] & xi[2]) | (xi[1] & xi[2]);
         for (int j = 1; j <= M-3; j++) begin
            a  = s;
            b  = xi[j+2];
            c  = cin[j-1];
            s  = a ^ b ^ c;
            cy = (a & b) | (a & c) | (b & c);
            if (j < M-3) res[j] = cy;
            else         res[CiW+1] = cy;
         end
         res[CiW] = s;
      end else begin
         p[M-1:0]     = xi;
         p[M+CiW-1:M] = cin;
         for (int k = 0; k <= M-3; k++) begin
            a  = p[3*k];
            b  = p[3*k+1];
            c  = p[3*k+2];
            p[2*M-3+k] = a ^ b ^ c;
            cy = (a & b) | (a & c) | (b & c);
            if (k < M-3) res[k] = cy;
            else         res[CiW+1] = cy;
         end
         res[CiW] = p[3*M-6];
      end
      return res;
   endfunction

   assign in_ready_o = rst_ni & ((state_q == IDLE) | (state_q == ACCUM));
   assign acc        = in_valid_i & in_ready_o;

   // A new transaction compresses against zero rather than the stale pair.
   always_comb begin
      sum_in   = (state_q == IDLE) ? '0 : sum_q;
      carry_in = (state_q == IDLE) ? '0 : carry_q;
      sum_d    = '0;
      carry_d  = '0;
      x        = '0;
      ci       = '0;
      r        = '0;
      for (int l = 0; l < Lanes; l++)
         op[l] = in_mask_i[l] ? AccWidth'(in_data_i[l*Width +: Width]) : '0;
      for (int bt = 0; bt < AccWidth; bt++) begin
         for (int l = 0; l < Lanes; l++) x[l] = op[l][bt];
         x[Lanes]   = sum_in[bt];
         x[Lanes+1] = carry_in[bt];
         r          = col_fn(x, ci);
         sum_d[bt]  = r[CiW];
         if (bt < AccWidth-1) carry_d[bt+1] = r[CiW+1];
         ci         = r[CiW-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACCUM: if (acc) state_d = in_last_i ? RESOLVE : ACCUM;
         RESOLVE:     state_d = OUTPUT;
         OUTPUT:      if (out_ready_i) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sum_q   <= '0;
         carry_q <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (acc) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            if (state_q == IDLE) begin
               cnt_q <= CntWidth'(1);
               ovf_q <= 1'b0;
            end else if (cnt_q == CntWidth'(MaxBeats)) begin
               ovf_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
         if (state_q == RESOLVE) res_q <= sum_q + carry_q;
      end
   end

   assign out_valid_o = rst_ni & (state_q == OUTPUT);
   assign out_sum_o   = rst_ni ? res_q : '0;
   assign out_count_o = rst_ni ? cnt_q : '0;
   assign out_ovf_o   = rst_ni & ovf_q;

endmodule

// File: tb/tb_cpr_accum_ctrl.sv
// Directed bench for cpr_accum_ctrl: beats drive a reference model whose results are
// queued on the last beat and checked when the tree and linear instances present output.
`timescale 1ns/1ps
module tb_cpr_accum_ctrl;
   localparam int W = 8, L = 4, MB = 4, AW = 12, CW = 3;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [L*W-1:0] in_data = '0;
   logic [L-1:0]  in_mask = '0;
   logic          in_ready, out_valid, out_ovf, in_ready_l, out_valid_l, out_ovf_l;
   logic [AW-1:0] out_sum, out_sum_l;
   logic [CW-1:0] out_count, out_count_l;

   always #5 clk = ~clk;

   cpr_accum_ctrl #(.Width(W), .Lanes(L), .MaxBeats(MB), .Speed(2'b10)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .in_mask_i(in_mask), .in_last_i(in_last),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sum_o(out_sum),
      .out_count_o(out_count), .out_ovf_o(out_ovf));

   cpr_accum_ctrl #(.Width(W), .Lanes(L), .MaxBeats(MB), .Speed(2'b00)) u_lin (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_l),
      .in_data_i(in_data), .in_mask_i(in_mask), .in_last_i(in_last),
      .out_valid_o(out_valid_l), .out_ready_i(out_ready), .out_sum_o(out_sum_l),
      .out_count_o(out_count_l), .out_ovf_o(out_ovf_l));

   typedef struct {
      logic [AW-1:0] sum;
      logic [CW-1:0] cnt;
      logic          ovf;
   } exp_t;

   exp_t          sb[$];
   int            total = 0, bad = 0;
   logic [AW-1:0] m_sum = '0;
   logic [CW-1:0] m_cnt = '0;
   logic          m_ovf = 1'b0;
   bit            in_txn = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [L*W-1:0] d, input logic [L-1:0] m, input logic last);
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_mask = m; in_last = last;
      chk("in_ready_beat", in_ready, 1);
      chk("in_ready_beat_lin", in_ready_l, 1);
      if (!in_txn) begin
         m_sum = '0; m_cnt = '0; m_ovf = 1'b0; in_txn = 1'b1;
      end
      for (int k = 0; k < L; k++)
         if (m[k]) m_sum = m_sum + AW'(d[k*W +: W]);
      if (m_cnt == CW'(MB)) m_ovf = 1'b1;
      else                  m_cnt = m_cnt + 1'b1;
      if (last) begin
         sb.push_back('{m_sum, m_cnt, m_ovf});
         in_txn = 1'b0;
      end
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Waits for the result, optionally holding back-pressure, then handshakes.
   task automatic get_out(input string tag, input int hold);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, 1);
      if (sb.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_data = '1; in_mask = '1; in_last = 1'b1;
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_in_ready"}, in_ready, 0);
         chk({tag, "_hold_sum"}, out_sum, e.sum);
         chk({tag, "_hold_count"}, out_count, e.cnt);
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk({tag, "_sum"}, out_sum, e.sum);
      chk({tag, "_count"}, out_count, e.cnt);
      chk({tag, "_ovf"}, out_ovf, e.ovf);
      chk({tag, "_valid_lin"}, out_valid_l, 1);
      chk({tag, "_sum_lin"}, out_sum_l, e.sum);
      chk({tag, "_count_lin"}, out_count_l, e.cnt);
      chk({tag, "_ovf_lin"}, out_ovf_l, e.ovf);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_post_valid"}, out_valid, 0);
      chk({tag, "_post_in_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [L*W-1:0] rd;
      logic [L-1:0]   rm;
      int             nb;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_count", out_count, 0);
      chk("rst_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      beat({8'd4, 8'd3, 8'd2, 8'd1}, 4'hF, 1'b1);
      get_out("single", 0);

      beat({4{8'hFF}}, 4'hF, 1'b0);
      beat({4{8'hFF}}, 4'hF, 1'b0);
      beat({4{8'hFF}}, 4'hF, 1'b1);
      get_out("three", 0);

      beat({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0101, 1'b1);
      get_out("mask_bp", 5);

      beat({8'd0, 8'd0, 8'd0, 8'd7}, 4'hF, 1'b1);
      get_out("after_bp", 0);

      for (int i = 0; i < 5; i++) beat({4{8'hFF}}, 4'hF, (i == 4));
      get_out("ovf", 0);

      // Overflow flag must not leak into the following transaction.
      beat({8'd1, 8'd2, 8'd3, 8'd4}, 4'b1000, 1'b1);
      get_out("ovf_clear", 0);

      beat({4{8'hFF}}, 4'hF, 1'b0);
      beat({4{8'hFF}}, 4'hF, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_sum", out_sum, 0);
      chk("midrst_count", out_count, 0);
      chk("midrst_ovf", out_ovf, 0);
      chk("midrst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      in_txn = 1'b0;
      beat({4{8'd1}}, 4'hF, 1'b1);
      get_out("post_rst", 0);

      for (int t = 0; t < 6; t++) begin
         nb = $urandom_range(1, 6);
         for (int i = 0; i < nb; i++) begin
            rd = $urandom;
            rm = 4'($urandom_range(0, 15));
            beat(rd, rm, (i == nb-1));
         end
         get_out("rand", (t % 2) * 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
